// File: rtl/lc3b_mem_responder.sv
// Memory-side responder for the LC-3b memory port: word storage with a fixed
// request-to-response latency, byte-masked writes and a sticky protocol error flag.
module lc3b_mem_responder #(
   parameter int unsigned DEPTH_LOG2 = 8,
   parameter int unsigned LATENCY    = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [15:0] mem_address,
   input  logic [15:0] mem_wdata,
   input  logic [1:0]  mem_byte_enable,
   output logic [15:0] mem_rdata,
   output logic        mem_resp,
   output logic        protocol_err
);

   localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
   localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                state;
   logic [3:0]            count;
   logic [DEPTH_LOG2-1:0] index;
   logic [15:0]           wdata;
   logic [1:0]            be;
   logic                  op_write;
   logic                  req;
   logic                  commit;
   logic                  unused_addr;

   logic [7:0] mem_lo [DEPTH];
   logic [7:0] mem_hi [DEPTH];

   assign req         = mem_read | mem_write;
   assign commit      = (state == S_RESP) && op_write;
   assign unused_addr = ^{mem_address[15:DEPTH_LOG2+1], mem_address[0]};

   // Storage is not reset; a reset forces state to IDLE asynchronously, so a
   // pending write can never reach this commit.
   always_ff @(posedge clk) begin
      if (commit && be[0]) mem_lo[index] <= wdata[7:0];
      if (commit && be[1]) mem_hi[index] <= wdata[15:8];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         count        <= '0;
         index        <= '0;
         wdata        <= '0;
         be           <= '0;
         op_write     <= 1'b0;
         mem_resp     <= 1'b0;
         mem_rdata    <= '0;
         protocol_err <= 1'b0;
      end else begin
         mem_resp <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (req) begin
                  index    <= mem_address[DEPTH_LOG2:1];
                  wdata    <= mem_wdata;
                  be       <= mem_byte_enable;
                  op_write <= mem_write;
                  count    <= LAT_M1;
                  if (mem_read && mem_write) protocol_err <= 1'b1;
                  state    <= (LATENCY == 1) ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               if (!req) begin
                  state <= S_IDLE;
                  count <= '0;
               end else begin
                  count <= count - 4'd1;
                  if (count == 4'd1) state <= S_RESP;
               end
            end
            S_RESP: begin
               // The pulse is registered here, so it is visible in the following
               // IDLE cycle; a still-held request is accepted at the end of it.
               mem_resp <= 1'b1;
               if (!op_write) mem_rdata <= {mem_hi[index], mem_lo[index]};
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Bench for lc3b_mem_responder: table of requests on a LATENCY=4 instance, abort,
// error and reset sequences, and back-to-back traffic on a LATENCY=1 instance.
module tb_lc3b_mem_responder;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [1:0]  be;
      logic [15:0] exp;
   } vec_t;

   typedef struct {
      logic        is_rd;
      logic [15:0] data;
   } sb_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        mem_read, mem_write;
   logic [15:0] mem_address, mem_wdata;
   logic [1:0]  mem_byte_enable;
   logic [15:0] mem_rdata;
   logic        mem_resp, protocol_err;

   logic        r1, w1;
   logic [15:0] a1, d1;
   logic [15:0] rdata1;
   logic        resp1, err1;

   int passed = 0;
   int total  = 0;
   sb_t q[$];
   sb_t q1[$];
   logic [15:0] last_rd = '0;
   logic [15:0] last1   = '0;

   always #5 clk = ~clk;

   lc3b_mem_responder #(.DEPTH_LOG2(8), .LATENCY(4)) dut (
      .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
      .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp), .protocol_err(protocol_err)
   );

   lc3b_mem_responder #(.DEPTH_LOG2(8), .LATENCY(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .mem_read(r1), .mem_write(w1),
      .mem_address(a1), .mem_wdata(d1), .mem_byte_enable(2'b11),
      .mem_rdata(rdata1), .mem_resp(resp1), .protocol_err(err1)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic do_op(input vec_t v, input string nm);
      sb_t e;
      int  n;
      @(negedge clk);
      mem_read        = v.rd;
      mem_write       = v.wr;
      mem_address     = v.addr;
      mem_wdata       = v.wdata;
      mem_byte_enable = v.be;
      e.is_rd = v.rd & ~v.wr;
      e.data  = e.is_rd ? v.exp : last_rd;
      if (e.is_rd) last_rd = v.exp;
      q.push_back(e);
      n = 0;
      do begin @(negedge clk); n++; end while (!mem_resp && n < 20);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      check({nm, " latency"}, n, 5);
      if (q.size() > 0) begin
         e = q.pop_front();
         check({nm, " rdata"}, mem_rdata, e.data);
      end
   endtask

   task automatic count_pulses(input int cycles, output int pulses);
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (mem_resp) pulses++;
      end
   endtask

   task automatic drive1(input int j);
      logic [15:0] addrs [6];
      logic [15:0] datas [3];
      sb_t e;
      addrs = '{16'h0002, 16'h0004, 16'h0006, 16'h0002, 16'h0004, 16'h0006};
      datas = '{16'hA1A1, 16'hB2B2, 16'hC3C3};
      w1 = (j < 3);
      r1 = (j >= 3);
      a1 = addrs[j];
      d1 = datas[j % 3];
      e.is_rd = (j >= 3);
      e.data  = e.is_rd ? datas[j - 3] : last1;
      if (e.is_rd) last1 = e.data;
      q1.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vecs [13];
      vec_t v;
      sb_t  e;
      int   n, pulses;

      vecs[0]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, 16'h0000};
      vecs[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF};
      vecs[2]  = '{1'b0, 1'b1, 16'h0020, 16'h1234, 2'b11, 16'h0000};
      vecs[3]  = '{1'b0, 1'b1, 16'h0020, 16'hAB00, 2'b10, 16'h0000};
      vecs[4]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 16'hAB34};
      vecs[5]  = '{1'b0, 1'b1, 16'h0020, 16'h00CD, 2'b01, 16'h0000};
      vecs[6]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 16'hABCD};
      vecs[7]  = '{1'b0, 1'b1, 16'h0020, 16'hFFFF, 2'b00, 16'h0000};
      vecs[8]  = '{1'b1, 1'b0, 16'h0021, 16'h0000, 2'b00, 16'hABCD};
      vecs[9]  = '{1'b0, 1'b1, 16'h0000, 16'h0F0F, 2'b11, 16'h0000};
      vecs[10] = '{1'b0, 1'b1, 16'h0200, 16'hC3C3, 2'b11, 16'h0000};
      vecs[11] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 2'b00, 16'hC3C3};
      vecs[12] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF};

      reset_n = 1'b0;
      mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wdata = '0; mem_byte_enable = '0;
      r1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0;
      repeat (3) @(negedge clk);
      check("reset resp", mem_resp, 0);
      check("reset rdata", mem_rdata, 16'h0000);
      check("reset err", protocol_err, 0);
      reset_n = 1'b1;

      for (int i = 0; i < 13; i++) do_op(vecs[i], $sformatf("vec%0d", i));

      // Abort: read dropped in the second WAIT cycle
      @(negedge clk);
      mem_read = 1'b1; mem_address = 16'h0020;
      @(negedge clk);
      @(negedge clk);
      mem_read = 1'b0;
      count_pulses(10, pulses);
      check("abort no resp", pulses, 0);
      check("abort rdata held", mem_rdata, last_rd);
      v = '{1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF};
      do_op(v, "after_abort");

      // Read and write together act as a write and latch the error flag
      v = '{1'b1, 1'b1, 16'h0040, 16'h7777, 2'b11, 16'h0000};
      do_op(v, "rdwr");
      check("err set", protocol_err, 1);
      v = '{1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 16'h7777};
      do_op(v, "rdwr_readback");
      check("err sticky", protocol_err, 1);

      // Reset during WAIT of a write discards it
      v = '{1'b0, 1'b1, 16'h0030, 16'h1111, 2'b11, 16'h0000};
      do_op(v, "pre_reset_wr");
      @(negedge clk);
      mem_write = 1'b1; mem_address = 16'h0030; mem_wdata = 16'h5555; mem_byte_enable = 2'b11;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("midreset resp", mem_resp, 0);
      check("midreset rdata", mem_rdata, 16'h0000);
      check("midreset err", protocol_err, 0);
      last_rd = '0;
      @(negedge clk);
      mem_write = 1'b0;
      reset_n = 1'b1;
      count_pulses(8, pulses);
      check("post reset no resp", pulses, 0);
      v = '{1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, 16'h1111};
      do_op(v, "reset_discard");
      check("err after reset", protocol_err, 0);

      // LATENCY=1 back-to-back with held request
      @(negedge clk);
      drive1(0);
      for (int i = 0; i < 6; i++) begin
         n = 0;
         do begin @(negedge clk); n++; end while (!resp1 && n < 10);
         check($sformatf("b2b%0d spacing", i), n, 2);
         if (q1.size() > 0) begin
            e = q1.pop_front();
            check($sformatf("b2b%0d rdata", i), rdata1, e.data);
         end
         if (i < 5) drive1(i + 1);
         else begin r1 = 1'b0; w1 = 1'b0; end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/lc3b_mem_responder.md
Name: lc3b_mem_responder

Overview:
- Memory-side responder for the LC-3b CPU memory port. It is the slave end of the read/write/resp handshake the datapath drives.
- Holds a word-organised storage array and services one request at a time with a fixed, parameterised latency.
- Honours the 2-bit byte write mask on writes.
- Sits below the CPU, or cache, in the system top. It replaces the behavioural memory for synthesis and for cycle-accurate simulation.

Parameters:
- DEPTH_LOG2, 8, log2 of storage depth in 16-bit words (256 words = 512 bytes).
- LATENCY, 4, cycles from request acceptance to mem_resp. Legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- mem_read  in  1  read request, held by requester until mem_resp
- mem_write  in  1  write request, held by requester until mem_resp
- mem_address  in  16  byte address (lc3b_word)
- mem_wdata  in  16  write data (lc3b_word)
- mem_byte_enable  in  2  write mask (lc3b_mem_wmask); bit0 = low byte, bit1 = high byte
- mem_rdata  out  16  read data; valid while mem_resp=1
- mem_resp  out  1  one-cycle completion pulse
- protocol_err  out  1  sticky error flag

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: state=IDLE, mem_resp=0, mem_rdata=16'h0000, protocol_err=0, latency counter=0. Storage contents are not reset.
- Word index = mem_address[DEPTH_LOG2:1]. mem_address[0] is ignored. Upper address bits are ignored, so addresses wrap modulo 2^(DEPTH_LOG2+1) bytes.
- IDLE:
  - If mem_read|mem_write is high at an edge: latch address, wdata, byte_enable and op; load counter with LATENCY-1; go to WAIT.
  - If LATENCY==1: go directly to RESP.
- WAIT:
  - Decrement counter each edge; go to RESP when counter reaches 0.
  - If the request drops (mem_read|mem_write==0) during WAIT: abort, return to IDLE, no write, no resp.
- RESP:
  - mem_resp=1 for exactly one cycle.
  - Read: mem_rdata = storage[latched index], whole word.
  - Write: on the RESP edge, storage low byte is written if be[0] and high byte if be[1]. be=2'b00 is a legal no-op write that still responds.
  - Next state is always IDLE.
- Timing: a request sampled at edge k makes mem_resp high in cycle k+LATENCY, i.e. after the edge k+LATENCY.
- Back-to-back requests: a request still asserted in the IDLE cycle after RESP is accepted as a new request. The minimum request spacing is LATENCY+1 cycles.
- mem_rdata holds its last value outside RESP. Write responses leave mem_rdata unchanged.
- Inputs are sampled only at acceptance. Changes to address or data during WAIT are ignored, except the abort rule above.
- mem_read and mem_write both high at acceptance: the access is treated as a write and protocol_err is set. protocol_err stays set until reset.
- Reset asserted mid-operation: immediate return to IDLE, mem_resp drops, any pending write is discarded.
- Read-after-write to the same address returns the new data. The write commits at the RESP edge, before any subsequent acceptance.

Test Plan:
- Write then read, LATENCY=4:
  - Write 16'hBEEF to 16'h0010 with be=11 -> resp 4 cycles after acceptance.
  - Read 16'h0010 -> rdata=16'hBEEF with resp 4 cycles later.
- Byte masks:
  - Write 16'h1234 to 16'h0020 (be=11), then 16'hAB00 with be=10 -> read gives 16'hAB34.
  - Then 16'h00CD with be=01 -> read gives 16'hABCD.
  - be=00 still gets resp, memory unchanged.
- Odd address and wrap:
  - Read 16'h0021 -> returns word at 16'h0020.
  - Write 16'h0200 with DEPTH_LOG2=8 -> aliases word 0.
- Abort: drop mem_read in the 2nd WAIT cycle -> no resp ever, state IDLE. A following read completes normally in LATENCY cycles.
- Error and reset:
  - read=write=1 -> acts as write, protocol_err=1 and stays set.
  - reset_n low during WAIT of a write -> resp never pulses, location unchanged, all outputs at reset values.
- LATENCY=1 and back-to-back: held mem_read -> resp pulses every 2 cycles, rdata updated each pulse.
